sram_image_loader: RTL and testbench
====================================

Name: sram_image_loader

Overview:
- Writer side of the image SRAM path: fills the external 16-bit SRAM with image words that the VGA image readers later fetch.
- Consumes a byte stream from the host-link receiver, using a valid/ready handshake.
- Packs each byte pair into a 16-bit word and writes the words to consecutive addresses, starting at a commanded base address.
- Holds all SRAM outputs released (address and data high-Z, write strobe inactive) when not loading, so the display readers own the bus.

Parameters:
- WE_LOW_CYCLES, 1: number of cycles o_sram_we_n is held low per word write (legal range 1..7).
- HIGH_BYTE_FIRST, 1: 1 means the first byte received goes to data[15:8]; 0 means it goes to data[7:0].

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous active-high reset.
- i_start  in  1  one-cycle load command; honoured only in S_IDLE.
- i_base_address  in  20  first SRAM word address; sampled when i_start is accepted.
- i_length  in  20  number of 16-bit words to write; sampled when i_start is accepted.
- i_abort  in  1  cancels the load immediately.
- i_byte  in  8  stream data.
- i_byte_valid  in  1  stream valid.
- o_byte_ready  out  1  stream ready.
- io_sram_data  inout  16  SRAM data bus; driven only in the write states, otherwise 16'dz.
- o_sram_address  out  20  word address; driven only while busy, otherwise 20'dz.
- o_sram_we_n  out  1  active-low write enable.
- o_busy  out  1  high in any state except S_IDLE.
- o_done  out  1  one-cycle pulse when the last word has been written.

Behaviour:
- Reset values (asynchronous, immediate on i_rst=1):
  - state S_IDLE; o_byte_ready=0; o_sram_we_n=1; o_busy=0; o_done=0.
  - Address and data outputs high-Z; all counters and registers cleared.
- State S_IDLE:
  - On i_start=1: latch base into addr_reg and length into len_reg; clear word_cnt and byte_phase.
  - If length==0, go to S_DONE; otherwise go to S_RECV.
- State S_RECV:
  - o_byte_ready=1. A byte is accepted on a cycle where i_byte_valid && o_byte_ready.
  - byte_phase=0: store the byte in the first-byte half per HIGH_BYTE_FIRST, then set byte_phase=1.
  - byte_phase=1: store the byte in the other half, clear byte_phase, go to S_WRITE.
- State S_WRITE:
  - o_byte_ready=0. Address = addr_reg, data = word_reg, o_sram_we_n=0.
  - Stay WE_LOW_CYCLES cycles (counted by wait_cnt), then go to S_HOLD.
- State S_HOLD:
  - One cycle with o_sram_we_n=1 while address and data are still driven (data hold after WE rising edge).
  - Then addr_reg+1, with 20-bit wrap 0xFFFFF -> 0x00000, and word_cnt+1.
  - If word_cnt+1==len_reg go to S_DONE, else go to S_RECV.
- State S_DONE: o_done=1 for exactly one cycle, o_busy=1, then S_IDLE.
- Throughput:
  - Minimum 2 + WE_LOW_CYCLES + 1 cycles per word (4 with the default).
  - The first byte of the next word can be accepted on the cycle after S_HOLD.
- i_start in any state other than S_IDLE is ignored; the latched base and length are unchanged.
- i_abort:
  - In any busy state, go to S_IDLE on the next edge.
  - o_sram_we_n=1 in that same next cycle; no o_done pulse; the partial word is discarded.
  - i_abort has priority over i_start in the same cycle; in S_IDLE, i_abort && i_start means the start is ignored.
- i_byte_valid while o_byte_ready=0: the byte is not consumed; the upstream holds it.
- The write strobe never toggles while the address changes: the address only updates on the S_HOLD -> next transition.

Decomposition:
- Shared package sram_pkg holds:
  - state enum {S_IDLE, S_RECV, S_WRITE, S_HOLD, S_DONE};
  - SRAM_ADDR_W=20 and SRAM_DATA_W=16;
  - the tri-state constants for the address and data buses, reused by the image readers.
- One natural sub-module: byte_packer. It holds the byte_phase flag and the word register, and raises word_valid when a pair is complete. The FSM, write timing and address counter stay in the top module.

Test Plan:
- Base 0x00010, length 2, bytes AB CD 12 34 (default parameters):
  - 0xABCD is written at 0x00010 and 0x1234 at 0x00011;
  - each write has WE low for 1 cycle, with data stable one cycle after WE rises;
  - o_done pulses once, and o_busy falls the cycle after.
- Length 0 -> o_done the cycle after the S_IDLE exit; no WE activity; o_byte_ready stays 0.
- Base 0xFFFFF, length 2 -> words land at 0xFFFFF and then 0x00000.
- i_byte_valid toggled 1/0 every cycle with HIGH_BYTE_FIRST=0 and bytes 11 22 -> 0x2211 is written; no bytes are lost or duplicated.
- Abort at the cycle WE is low in the second word of a 4-word load -> WE=1 the next cycle, buses go high-Z, no o_done; a subsequent start works from a clean byte_phase.
- i_start pulsed mid-load with a different base -> ignored. i_rst asserted mid-write -> WE=1 and buses go high-Z asynchronously.

Source files
------------

// File: rtl/sram_pkg.sv
// ============================================================================
// sram_pkg
//   Shared SRAM bus widths, released-bus constants and loader state encoding.
//   Rev 1.0
// ============================================================================
`default_nettype none

package sram_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;

  // Values placed on the shared bus when this master lets go of it
  localparam logic [SRAM_ADDR_W-1:0] c_sram_addr_z = {SRAM_ADDR_W{1'bz}};
  localparam logic [SRAM_DATA_W-1:0] c_sram_data_z = {SRAM_DATA_W{1'bz}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/byte_packer.sv
// ============================================================================
// byte_packer
//   Assembles consecutive stream bytes into a 16-bit SRAM word.
//   Rev 1.0
// ============================================================================
`default_nettype none

module byte_packer
  import sram_pkg::*;
#(
  parameter bit HIGH_BYTE_FIRST = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clear,
  input  logic                   i_accept,
  input  logic [7:0]             i_byte,
  output logic [SRAM_DATA_W-1:0] o_word,
  output logic                   o_word_valid
);

  logic                   r_phase;
  logic [SRAM_DATA_W-1:0] r_word;
  logic                   w_to_high;

  // Upper half takes the first byte when HIGH_BYTE_FIRST, the second otherwise
  assign w_to_high    = r_phase ^ HIGH_BYTE_FIRST;
  assign o_word_valid = i_accept && r_phase && !i_clear;
  assign o_word       = r_word;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_phase <= 1'b0;
      r_word  <= '0;
    end else if (i_clear) begin
      r_phase <= 1'b0;
    end else if (i_accept) begin
      r_phase <= ~r_phase;
      if (w_to_high) r_word[15:8] <= i_byte;
      else           r_word[7:0]  <= i_byte;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_image_loader.sv
// ============================================================================
// sram_image_loader
//   Streams host bytes into the image SRAM as 16-bit words at consecutive
//   addresses, releasing the bus to the display readers whenever idle.
//   Rev 1.0
// ============================================================================
`default_nettype none

module sram_image_loader
  import sram_pkg::*;
#(
  parameter int WE_LOW_CYCLES   = 1,
  parameter bit HIGH_BYTE_FIRST = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [SRAM_ADDR_W-1:0] i_base_address,
  input  logic [SRAM_ADDR_W-1:0] i_length,
  input  logic                   i_abort,
  input  logic [7:0]             i_byte,
  input  logic                   i_byte_valid,
  output logic                   o_byte_ready,
  inout  wire  [SRAM_DATA_W-1:0] io_sram_data,
  output logic [SRAM_ADDR_W-1:0] o_sram_address,
  output logic                   o_sram_we_n,
  output logic                   o_busy,
  output logic                   o_done
);

  state_t                 r_state;
  state_t                 w_next;
  logic [SRAM_ADDR_W-1:0] r_addr;
  logic [SRAM_ADDR_W-1:0] r_len;
  logic [SRAM_ADDR_W-1:0] r_word_cnt;
  logic [2:0]             r_wait_cnt;
  logic                   r_we_n;

  logic                   w_start_ok;
  logic                   w_accept;
  logic                   w_word_valid;
  logic                   w_last;
  logic                   w_wait_done;
  logic                   w_drive_data;
  logic [SRAM_DATA_W-1:0] w_word;
  logic [SRAM_ADDR_W-1:0] w_cnt_inc;

  assign w_start_ok  = (r_state == S_IDLE) && i_start && !i_abort;
  assign w_accept    = i_byte_valid && o_byte_ready;
  assign w_cnt_inc   = r_word_cnt + 1'b1;
  assign w_last      = (w_cnt_inc == r_len);
  assign w_wait_done = (r_wait_cnt == 3'(WE_LOW_CYCLES - 1));

  byte_packer #(
    .HIGH_BYTE_FIRST(HIGH_BYTE_FIRST)
  ) u_packer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (w_start_ok || i_abort),
    .i_accept    (w_accept),
    .i_byte      (i_byte),
    .o_word      (w_word),
    .o_word_valid(w_word_valid)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    o_byte_ready = 1'b0;
    o_busy       = (r_state != S_IDLE);
    o_done       = 1'b0;
    w_drive_data = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_next = (i_length == '0) ? S_DONE : S_RECV;
      end
      S_RECV: begin
        o_byte_ready = 1'b1;
        if (w_word_valid) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_drive_data = 1'b1;
        if (w_wait_done) w_next = S_HOLD;
      end
      S_HOLD: begin
        w_drive_data = 1'b1;
        w_next       = w_last ? S_DONE : S_RECV;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (i_abort) w_next = S_IDLE;
  end

  // Strobe comes straight from a flop so it cannot glitch on state decode
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr     <= '0;
      r_len      <= '0;
      r_word_cnt <= '0;
      r_wait_cnt <= '0;
      r_we_n     <= 1'b1;
    end else begin
      r_we_n <= (w_next != S_WRITE);
      if (r_state == S_WRITE) r_wait_cnt <= r_wait_cnt + 3'd1;
      else                    r_wait_cnt <= '0;
      if (w_start_ok) begin
        r_addr     <= i_base_address;
        r_len      <= i_length;
        r_word_cnt <= '0;
      end else if (r_state == S_HOLD && !i_abort) begin
        r_addr     <= r_addr + 1'b1;
        r_word_cnt <= w_cnt_inc;
      end
    end
  end

  assign o_sram_we_n    = r_we_n;
  assign o_sram_address = o_busy ? r_addr : c_sram_addr_z;
  assign io_sram_data   = w_drive_data ? w_word : c_sram_data_z;

endmodule

`default_nettype wire

// File: tb/tb_sram_image_loader.sv
// ============================================================================
// tb_sram_image_loader
//   Directed bench for the image SRAM loader (default and low-byte-first).
//   Rev 1.0
// ============================================================================
`default_nettype none

module tb_sram_image_loader;

  localparam logic [19:0] REL_ADDR = 20'hFFFFF;
  localparam logic [15:0] REL_DATA = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start_lo = 1'b0;
  logic [19:0] base = '0;
  logic [19:0] length = '0;
  logic        abort = 1'b0;
  logic [7:0]  byte_d = '0;
  logic        byte_valid = 1'b0;

  logic        ready, we_n, busy, done;
  logic        ready_lo, we_n_lo, busy_lo, done_lo;
  tri1  [15:0] sram_data;
  tri1  [19:0] sram_addr;
  tri1  [15:0] sram_data_lo;
  tri1  [19:0] sram_addr_lo;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  sram_image_loader dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_address(base),
    .i_length(length), .i_abort(abort), .i_byte(byte_d), .i_byte_valid(byte_valid),
    .o_byte_ready(ready), .io_sram_data(sram_data), .o_sram_address(sram_addr),
    .o_sram_we_n(we_n), .o_busy(busy), .o_done(done)
  );

  sram_image_loader #(.WE_LOW_CYCLES(1), .HIGH_BYTE_FIRST(1'b0)) dut_lo (
    .i_clk(clk), .i_rst(rst), .i_start(start_lo), .i_base_address(base),
    .i_length(length), .i_abort(abort), .i_byte(byte_d), .i_byte_valid(byte_valid),
    .o_byte_ready(ready_lo), .io_sram_data(sram_data_lo), .o_sram_address(sram_addr_lo),
    .o_sram_we_n(we_n_lo), .o_busy(busy_lo), .o_done(done_lo)
  );

  // Write log of the default instance, one entry per WE rising edge
  int          cyc = 0;
  int          wr_n = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          low_cnt = 0;
  logic        prev_we = 1'b1;
  logic [19:0] low_addr = '0;
  logic [15:0] low_data = '0;
  logic [19:0] wr_addr [0:31];
  logic [15:0] wr_data [0:31];
  int          wr_low [0:31];
  logic        wr_stable [0:31];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (we_n === 1'b0) begin
      low_cnt  <= low_cnt + 1;
      low_addr <= sram_addr;
      low_data <= sram_data;
    end else if (prev_we === 1'b0 && wr_n < 32) begin
      wr_addr[wr_n]   <= sram_addr;
      wr_data[wr_n]   <= sram_data;
      wr_low[wr_n]    <= low_cnt;
      wr_stable[wr_n] <= (sram_addr === low_addr) && (sram_data === low_data);
      wr_n            <= wr_n + 1;
      low_cnt         <= 0;
    end
    prev_we <= we_n;
  end

  task automatic do_start(input logic [19:0] b, input logic [19:0] l);
    @(posedge clk); #1;
    start = 1'b1; base = b; length = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_d = b; byte_valid = 1'b1;
    @(negedge clk);
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
    if (n >= 100) begin
      tests++; failed++;
      $display("FAIL send_byte timeout: ready stayed %b, required 1", ready);
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (done !== 1'b1) begin
      failed++; $display("FAIL %s done timeout: done=%b, required 1", name, done);
    end
    tests++;
    if (busy !== 1'b1) begin
      failed++; $display("FAIL %s busy_at_done: got %b, required 1", name, busy);
    end
    @(negedge clk); #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failed++; $display("FAIL %s after_done: busy=%b done=%b, required 0 0", name, busy, done);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if (ready !== 1'b0 || we_n !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failed++;
      $display("FAIL reset_ctrl: ready=%b we_n=%b busy=%b done=%b, required 0 1 0 0", ready, we_n, busy, done);
    end
    tests++;
    if (sram_addr !== REL_ADDR || sram_data !== REL_DATA) begin
      failed++; $display("FAIL reset_bus: addr=%h data=%h, required released", sram_addr, sram_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int b0, d0, sc;
    b0 = wr_n; d0 = done_cnt;
    do_start(20'h00010, 20'd2);
    sc = cyc;
    send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h12); send_byte(8'h34);
    wait_done("basic");
    tests++;
    if (wr_n - b0 != 2) begin
      failed++; $display("FAIL basic_count: got %0d writes, required 2", wr_n - b0);
    end
    tests++;
    if (wr_addr[b0] !== 20'h00010 || wr_data[b0] !== 16'hABCD) begin
      failed++; $display("FAIL basic_w0: %h@%h, required abcd@00010", wr_data[b0], wr_addr[b0]);
    end
    tests++;
    if (wr_addr[b0+1] !== 20'h00011 || wr_data[b0+1] !== 16'h1234) begin
      failed++; $display("FAIL basic_w1: %h@%h, required 1234@00011", wr_data[b0+1], wr_addr[b0+1]);
    end
    tests++;
    if (wr_low[b0] != 1 || wr_low[b0+1] != 1) begin
      failed++; $display("FAIL basic_we_width: got %0d/%0d, required 1/1", wr_low[b0], wr_low[b0+1]);
    end
    tests++;
    if (wr_stable[b0] !== 1'b1 || wr_stable[b0+1] !== 1'b1) begin
      failed++; $display("FAIL basic_hold: stable=%b/%b, required 1/1", wr_stable[b0], wr_stable[b0+1]);
    end
    tests++;
    if (done_cnt - d0 != 1) begin
      failed++; $display("FAIL basic_done_pulses: got %0d, required 1", done_cnt - d0);
    end
    tests++;
    if (done_cyc - sc != 8) begin
      failed++; $display("FAIL basic_latency: got %0d cycles, required 8", done_cyc - sc);
    end
    tests++;
    if (sram_addr !== REL_ADDR || sram_data !== REL_DATA || we_n !== 1'b1) begin
      failed++; $display("FAIL basic_release: addr=%h data=%h we_n=%b", sram_addr, sram_data, we_n);
    end
  endtask

  task automatic test_len0();
    int b0, d0;
    b0 = wr_n; d0 = done_cnt;
    do_start(20'h00020, 20'd0);
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || ready !== 1'b0 || we_n !== 1'b1) begin
      failed++; $display("FAIL len0_done: done=%b ready=%b we_n=%b, required 1 0 1", done, ready, we_n);
    end
    @(negedge clk); #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || wr_n != b0 || done_cnt - d0 != 1) begin
      failed++;
      $display("FAIL len0_after: done=%b busy=%b writes=%0d pulses=%0d, required 0 0 0 1", done, busy, wr_n - b0, done_cnt - d0);
    end
  endtask

  task automatic test_wrap();
    int b0;
    b0 = wr_n;
    do_start(20'hFFFFF, 20'd2);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    wait_done("wrap");
    tests++;
    if (wr_addr[b0] !== 20'hFFFFF || wr_data[b0] !== 16'h0102) begin
      failed++; $display("FAIL wrap_w0: %h@%h, required 0102@fffff", wr_data[b0], wr_addr[b0]);
    end
    tests++;
    if (wr_addr[b0+1] !== 20'h00000 || wr_data[b0+1] !== 16'h0304) begin
      failed++; $display("FAIL wrap_w1: %h@%h, required 0304@00000", wr_data[b0+1], wr_addr[b0+1]);
    end
  endtask

  task automatic test_toggle_low_first();
    logic [7:0]  bl [0:1];
    logic [19:0] got_addr;
    logic [15:0] got_data;
    int idx, we_cycles, done_seen;
    logic acc;
    bl[0] = 8'h11; bl[1] = 8'h22;
    idx = 0; we_cycles = 0; done_seen = 0;
    got_addr = '0; got_data = '0;
    @(posedge clk); #1;
    start_lo = 1'b1; base = 20'h00100; length = 20'd1;
    @(posedge clk); #1;
    start_lo = 1'b0;
    for (int k = 0; k < 30; k++) begin
      byte_valid = (k % 2 == 0) && (idx < 2);
      byte_d     = (idx < 2) ? bl[idx] : 8'h00;
      @(negedge clk);
      acc = byte_valid && (ready_lo === 1'b1);
      if (we_n_lo === 1'b0) begin
        we_cycles++; got_addr = sram_addr_lo; got_data = sram_data_lo;
      end
      if (done_lo === 1'b1) done_seen++;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    byte_valid = 1'b0;
    tests++;
    if (idx != 2) begin
      failed++; $display("FAIL toggle_accepted: got %0d bytes, required 2", idx);
    end
    tests++;
    if (got_data !== 16'h2211 || got_addr !== 20'h00100) begin
      failed++; $display("FAIL toggle_word: %h@%h, required 2211@00100", got_data, got_addr);
    end
    tests++;
    if (we_cycles != 1 || done_seen != 1) begin
      failed++; $display("FAIL toggle_strobes: we=%0d done=%0d, required 1 1", we_cycles, done_seen);
    end
  endtask

  task automatic test_abort();
    int b0, b1, d0, n;
    b0 = wr_n; d0 = done_cnt; n = 0;
    do_start(20'h00200, 20'd4);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    @(negedge clk);
    while (!(we_n === 1'b0 && wr_n == b0 + 1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (we_n !== 1'b0 || sram_addr !== 20'h00201 || sram_data !== 16'hCCDD) begin
      failed++; $display("FAIL abort_w1_low: we_n=%b %h@%h, required 0 ccdd@00201", we_n, sram_data, sram_addr);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    tests++;
    if (we_n !== 1'b1 || busy !== 1'b0 || sram_addr !== REL_ADDR || sram_data !== REL_DATA) begin
      failed++;
      $display("FAIL abort_release: we_n=%b busy=%b addr=%h data=%h, required 1 0 released", we_n, busy, sram_addr, sram_data);
    end
    repeat (5) @(negedge clk);
    tests++;
    if (done_cnt != d0 || wr_addr[b0] !== 20'h00200 || wr_data[b0] !== 16'hAABB) begin
      failed++; $display("FAIL abort_nodone: pulses=%0d w0=%h@%h, required 0 aabb@00200", done_cnt - d0, wr_data[b0], wr_addr[b0]);
    end
    b1 = wr_n;
    do_start(20'h00300, 20'd1);
    send_byte(8'h5A); send_byte(8'hA5);
    wait_done("abort_restart");
    tests++;
    if (wr_n - b1 != 1 || wr_addr[b1] !== 20'h00300 || wr_data[b1] !== 16'h5AA5) begin
      failed++; $display("FAIL abort_restart: %0d writes %h@%h, required 1 5aa5@00300", wr_n - b1, wr_data[b1], wr_addr[b1]);
    end
  endtask

  task automatic test_start_ignored();
    int b0, d0;
    b0 = wr_n; d0 = done_cnt;
    do_start(20'h00400, 20'd2);
    send_byte(8'h10); send_byte(8'h20);
    do_start(20'h00500, 20'd1);
    send_byte(8'h30); send_byte(8'h40);
    wait_done("start_ignored");
    tests++;
    if (wr_n - b0 != 2 || done_cnt - d0 != 1) begin
      failed++; $display("FAIL ignore_count: writes=%0d pulses=%0d, required 2 1", wr_n - b0, done_cnt - d0);
    end
    tests++;
    if (wr_addr[b0] !== 20'h00400 || wr_addr[b0+1] !== 20'h00401 || wr_data[b0+1] !== 16'h3040) begin
      failed++; $display("FAIL ignore_addr: %h %h data %h, required 00400 00401 3040", wr_addr[b0], wr_addr[b0+1], wr_data[b0+1]);
    end
  endtask

  task automatic test_rst_mid_write();
    int n;
    n = 0;
    do_start(20'h00600, 20'd1);
    send_byte(8'h66); send_byte(8'h77);
    @(negedge clk);
    while (we_n !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (we_n !== 1'b1 || busy !== 1'b0 || sram_addr !== REL_ADDR || sram_data !== REL_DATA) begin
      failed++;
      $display("FAIL rst_async: we_n=%b busy=%b addr=%h data=%h, required 1 0 released", we_n, busy, sram_addr, sram_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len0();
    test_wrap();
    test_toggle_low_first();
    test_abort();
    test_start_ignored();
    test_rst_mid_write();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
